melody_player: RTL and testbench



---
 rtl/melody_player.sv | 151 +++++++++++++++
 tb/tb_melody_player.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// Steps the note ROM index through 64 fixed-length note slots and renders each
// latched divider value as a square wave, with a silent gap closing every slot.
module melody_player #(
    parameter int BW         = 16,
    parameter int NOTE_TICKS = 1500000,
    parameter int GAP_TICKS  = 150000,
    parameter int CNT_BW     = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_i,
    input  logic [BW-1:0] dividerValue_i,
    output logic [5:0]    noteIndex_o,
    output logic          tone_o,
    output logic          playing_o,
    output logic          done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // Slot timer value: FETCH is 0, PLAY runs 1..PLAY_LAST, GAP runs up to SLOT_LAST.
    localparam logic [CNT_BW-1:0] PLAY_LAST = CNT_BW'(NOTE_TICKS - GAP_TICKS - 1);
    localparam logic [CNT_BW-1:0] SLOT_LAST = CNT_BW'(NOTE_TICKS - 1);

    logic [1:0]        state_reg, state_next;
    logic [CNT_BW-1:0] slot_reg,  slot_next;
    logic [BW-1:0]     hcnt_reg,  hcnt_next;
    logic [BW-1:0]     div_reg,   div_next;
    logic [5:0]        idx_reg,   idx_next;
    logic              tone_reg,  tone_next;
    logic              done_reg,  done_next;
    logic              slot_end;

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        hcnt_next  = hcnt_reg;
        div_next   = div_reg;
        idx_next   = idx_reg;
        tone_next  = tone_reg;
        done_next  = 1'b0;
        slot_end   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                tone_next = 1'b0;
                slot_next = '0;
                hcnt_next = '0;
                if (start_i && !stop_i) begin
                    state_next = S_FETCH;
                    idx_next   = 6'd0;
                end
            end
            S_FETCH: begin
                div_next   = dividerValue_i;
                hcnt_next  = '0;
                tone_next  = 1'b0;
                slot_next  = slot_reg + 1'b1;
                state_next = S_PLAY;
            end
            S_PLAY: begin
                slot_next = slot_reg + 1'b1;
                // A zero divider is a rest: keep the output and counter parked.
                if (div_reg == '0) begin
                    hcnt_next = '0;
                    tone_next = 1'b0;
                end else if (hcnt_reg == div_reg - BW'(1)) begin
                    hcnt_next = '0;
                    tone_next = ~tone_reg;
                end else begin
                    hcnt_next = hcnt_reg + BW'(1);
                end
                // With no gap configured the last PLAY cycle also closes the slot.
                if (slot_reg == SLOT_LAST) begin
                    slot_end = 1'b1;
                end else if (slot_reg == PLAY_LAST) begin
                    state_next = S_GAP;
                    tone_next  = 1'b0;
                end
            end
            S_GAP: begin
                tone_next = 1'b0;
                slot_next = slot_reg + 1'b1;
                if (slot_reg == SLOT_LAST) begin
                    slot_end = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (slot_end) begin
            slot_next = '0;
            tone_next = 1'b0;
            hcnt_next = '0;
            if (idx_reg != 6'd63) begin
                idx_next   = idx_reg + 6'd1;
                state_next = S_FETCH;
            end else if (loop_i) begin
                idx_next   = 6'd0;
                state_next = S_FETCH;
            end else begin
                idx_next   = 6'd0;
                state_next = S_IDLE;
                done_next  = 1'b1;
            end
        end

        // Abort takes priority over everything once playback is under way.
        if (stop_i && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            idx_next   = 6'd0;
            tone_next  = 1'b0;
            hcnt_next  = '0;
            slot_next  = '0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            slot_reg  <= '0;
            hcnt_reg  <= '0;
            div_reg   <= '0;
            idx_reg   <= 6'd0;
            tone_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
            hcnt_reg  <= hcnt_next;
            div_reg   <= div_next;
            idx_reg   <= idx_next;
            tone_reg  <= tone_next;
            done_reg  <= done_next;
        end
    end

    assign noteIndex_o = idx_reg;
    assign tone_o      = tone_reg;
    assign playing_o   = (state_reg != S_IDLE);
    assign done_o      = done_reg;

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player: a slot-position model queues expected
// outputs each clock and they are compared against the DUT on the falling edge.
module tb_melody_player;

    localparam int BW       = 16;
    localparam int NT       = 40;
    localparam int GT       = 4;
    localparam int CB       = 24;
    localparam int PLAY_END = NT - GT - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          loop_i = 1'b0;
    logic [BW-1:0] div_val;
    logic [5:0]    noteIndex_o;
    logic          tone_o;
    logic          playing_o;
    logic          done_o;

    melody_player #(.BW(BW), .NOTE_TICKS(NT), .GAP_TICKS(GT), .CNT_BW(CB)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .loop_i         (loop_i),
        .dividerValue_i (div_val),
        .noteIndex_o    (noteIndex_o),
        .tone_o         (tone_o),
        .playing_o      (playing_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    endtask

    // Stub ROM: mode 0 = all 3, mode 1 = rest at index 2 else 5, mode 2 = all 1.
    int rom_mode = 0;
    bit perturb  = 1'b0;
    bit m_active = 1'b0;
    int m_pos    = 0;
    int m_idx    = 0;
    int m_div    = 0;
    bit m_done   = 1'b0;

    always_comb begin
        logic [BW-1:0] base;
        base = 16'd3;
        if (rom_mode == 1) base = (noteIndex_o == 6'd2) ? 16'd0 : 16'd5;
        else if (rom_mode == 2) base = 16'd1;
        div_val = base + ((perturb && m_pos != 0) ? 16'd4 : 16'd0);
    end

    typedef struct packed {
        logic [5:0] idx;
        logic       tone;
        logic       playing;
        logic       done;
    } exp_t;
    exp_t exp_q[$];

    // Tone seen at slot position p reflects the toggles of PLAY cycles 1..p-1.
    function automatic logic exp_tone(input bit act, input int pos, input int dv);
        if (!act || pos < 2 || pos > PLAY_END || dv == 0) return 1'b0;
        return (((pos - 1) / dv) % 2) == 1;
    endfunction

    always @(posedge clk) begin
        bit a, dn;
        int p, i, d;
        exp_t e;
        a = m_active; p = m_pos; i = m_idx; d = m_div; dn = 1'b0;
        if (rst) begin
            a = 1'b0; p = 0; i = 0; d = 0;
        end else if (a) begin
            if (stop_i) begin
                a = 1'b0; p = 0; i = 0;
            end else if (p == NT - 1) begin
                p = 0;
                if (i < 63) i = i + 1;
                else if (loop_i) i = 0;
                else begin a = 1'b0; i = 0; dn = 1'b1; end
            end else begin
                if (p == 0) d = int'(div_val);
                p = p + 1;
            end
        end else if (start_i && !stop_i) begin
            a = 1'b1; p = 0; i = 0;
        end
        m_active <= a; m_pos <= p; m_idx <= i; m_div <= d; m_done <= dn;
        cyc <= cyc + 1;
        e.idx = 6'(i); e.tone = exp_tone(a, p, d); e.playing = a; e.done = dn;
        exp_q.push_back(e);
    end

    int slot_hi[64];
    int slot_tr[64];
    int hi_cnt = 0;
    int tr_cnt = 0;
    int done_seen = 0;
    logic prev_tone = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("idx", noteIndex_o, e.idx);
            check("tone", tone_o, e.tone);
            check("playing", playing_o, e.playing);
            check("done", done_o, e.done);
        end
        if (m_active) begin
            hi_cnt <= (m_pos == 0 ? 0 : hi_cnt) + int'(tone_o);
            tr_cnt <= (m_pos == 0) ? 0 :
                      tr_cnt + int'(m_pos >= 2 && m_pos <= PLAY_END && tone_o != prev_tone);
            if (m_pos == NT - 1) begin
                slot_hi[m_idx] <= hi_cnt + int'(tone_o);
                slot_tr[m_idx] <= tr_cnt;
            end
        end
        prev_tone <= tone_o;
        if (done_o) done_seen <= done_seen + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_slot(input string tag, input int idx, input int pos, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (m_active && m_idx == idx && m_pos == pos) begin ok = 1'b1; break; end
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_done(input string tag, input int budget, output int c);
        bit ok = 1'b0;
        c = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_o) begin ok = 1'b1; c = cyc; break; end
        end
        check(tag, ok, 1);
    endtask

    task automatic pulse_start(output int t0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        int t0, c, base_done;
        bit ok;

        step(3);
        check("rst_idx", noteIndex_o, 0);
        check("rst_playing", playing_o, 0);
        rst = 1'b0;
        step(5);
        check("idle_playing", playing_o, 0);

        // Full pass with divider 3
        rom_mode = 0;
        pulse_start(t0);
        wait_done("pass_done", 3000, c);
        check("pass_len", c - t0, NT * 64);
        check("play_at_done", playing_o, 0);
        step(5);
        check("done_once", done_seen, 1);
        check("tr_div3_s5", slot_tr[5], 11);
        check("tr_div3_s63", slot_tr[63], 11);
        check("hi_div3_s5", slot_hi[5], 17);

        // Rest note at index 2
        rom_mode = 1;
        pulse_start(t0);
        wait_slot("wait_rest", 4, 0, 400);
        check("rest_hi_s2", slot_hi[2], 0);
        check("tr_div5_s1", slot_tr[1], 6);
        check("tr_div5_s3", slot_tr[3], 6);
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
        check("stop_rest_idle", playing_o, 0);

        // Looping, then drop loop in the second pass
        rom_mode = 0;
        loop_i = 1'b1;
        base_done = done_seen;
        pulse_start(t0);
        wait_slot("wait_wrap", 63, NT - 1, 2700);
        step(1);
        check("wrap_idx", noteIndex_o, 0);
        check("wrap_playing", playing_o, 1);
        wait_slot("wait_pass2", 10, 5, 600);
        check("no_done_on_wrap", done_seen, base_done);
        loop_i = 1'b0;
        wait_done("loop_done", 2700, c);
        step(2);
        check("loop_done_once", done_seen, base_done + 1);

        // Stop at PLAY cycle 10 of index 7
        base_done = done_seen;
        pulse_start(t0);
        wait_slot("wait_stop", 7, 10, 400);
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
        check("stop_playing", playing_o, 0);
        check("stop_idx", noteIndex_o, 0);
        check("stop_tone", tone_o, 0);
        start_i = 1'b1;
        stop_i  = 1'b1;
        step(5);
        check("start_stop_idle", playing_o, 0);
        start_i = 1'b0;
        stop_i  = 1'b0;
        step(3);
        check("stop_no_done", done_seen, base_done);

        // Divider 1, then dividerValue_i disturbed outside FETCH
        rom_mode = 2;
        pulse_start(t0);
        wait_slot("wait_div1", 2, 0, 200);
        perturb = 1'b1;
        wait_slot("wait_mode", 4, 5, 200);
        rom_mode = 0;
        wait_slot("wait_s6", 6, 0, 200);
        check("tr_div1_s0", slot_tr[0], 34);
        check("tr_div1_s1", slot_tr[1], 34);
        check("tr_perturb_s2", slot_tr[2], 34);
        check("tr_midchange_s4", slot_tr[4], 34);
        check("tr_newdiv_s5", slot_tr[5], 11);
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
        perturb = 1'b0;

        // Async reset while tone is high
        pulse_start(t0);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tone_o && playing_o) begin ok = 1'b1; break; end
        end
        check("tone_high_seen", ok, 1);
        base_done = done_seen;
        #2 rst = 1'b1;
        #1;
        check("arst_tone", tone_o, 0);
        check("arst_playing", playing_o, 0);
        check("arst_idx", noteIndex_o, 0);
        step(3);
        rst = 1'b0;
        step(20);
        check("post_rst_idle", playing_o, 0);
        check("post_rst_no_done", done_seen, base_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
